// File: rtl/handshake_fifo.sv
// handshake_fifo: circular-buffer FIFO with a request/acknowledge handshake on
// both sides. On the left this block requests words from an upstream producer;
// on the right it answers requests from a downstream consumer. At most one
// upstream request is outstanding, so a write never lands on a full buffer.
module handshake_fifo #(
    parameter int                    data_width    = 32,
    parameter int                    depth         = 4,
    parameter logic [data_width-1:0] initial_value = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    req_l,
    input  logic                    ack_l,
    input  logic [data_width-1:0]   din,
    input  logic                    req_r,
    output logic                    ack_r,
    output logic [data_width-1:0]   dout,
    output logic [$clog2(depth):0]  level,
    output logic [31:0]             count
);

    localparam int                PTR_W     = $clog2(depth);
    localparam int                LVL_W     = PTR_W + 1;
    localparam logic [LVL_W-1:0]  C_DEPTH   = LVL_W'(depth);
    localparam logic [LVL_W-1:0]  C_LVL_ONE = LVL_W'(1);
    localparam logic [LVL_W-1:0]  C_LVL_ZERO = LVL_W'(0);
    localparam logic [PTR_W-1:0]  C_PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W-1:0]  C_PTR_ZERO = PTR_W'(0);

    logic [data_width-1:0] r_mem [depth];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic                  r_req_l;
    logic                  r_ack_r;
    logic [data_width-1:0] r_dout;
    logic [31:0]           r_count;

    logic                  w_not_full;
    logic                  w_not_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_req_l_nxt;
    logic [LVL_W-1:0]      w_level_nxt;

    // Push/pop qualification; an ack without an outstanding request is ignored.
    always_comb begin
        w_not_full  = (r_level < C_DEPTH);
        w_not_empty = (r_level != C_LVL_ZERO);
        w_push      = ack_l & r_req_l & w_not_full;
        w_pop       = req_r & ~r_ack_r & w_not_empty;
    end

    // Upstream request: drop on the accepted ack, raise when space is available.
    always_comb begin
        w_req_l_nxt = r_req_l;
        if (w_push) begin
            w_req_l_nxt = 1'b0;
        end else if (!r_req_l && w_not_full) begin
            w_req_l_nxt = 1'b1;
        end else begin
            w_req_l_nxt = r_req_l;
        end
    end

    // Occupancy update; simultaneous push and pop leave it unchanged.
    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + C_LVL_ONE;
            2'b01:   w_level_nxt = r_level - C_LVL_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    // Storage write; memory contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and handshake state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= C_PTR_ZERO;
            r_rd_ptr <= C_PTR_ZERO;
            r_level  <= C_LVL_ZERO;
            r_req_l  <= 1'b0;
            r_ack_r  <= 1'b0;
            r_dout   <= initial_value;
            r_count  <= 32'd0;
        end else begin
            r_level <= w_level_nxt;
            r_req_l <= w_req_l_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_ack_r  <= 1'b1;
                r_dout   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
                r_count  <= r_count + 32'd1;
            end else begin
                r_ack_r  <= 1'b0;
            end
        end
    end

    assign req_l = r_req_l;
    assign ack_r = r_ack_r;
    assign dout  = r_dout;
    assign level = r_level;
    assign count = r_count;

endmodule

// File: tb/tb_handshake_fifo.sv
// Bench for handshake_fifo: three instances (depth 4, 2, 8), each with its own
// producer, consumer, expected-word queue and output monitor. Instance 0 runs
// the directed scenarios; instances 1 and 2 run the back-pressure stream.
module tb_handshake_fifo;

    logic clk = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int DEPTH = (gi == 0) ? 4 : ((gi == 1) ? 2 : 8);
        localparam int LW    = $clog2(DEPTH) + 1;

        logic          rst   = 1'b1;
        logic          req_l;
        logic          ack_l = 1'b0;
        logic [31:0]   din   = 32'd0;
        logic          req_r = 1'b0;
        logic          ack_r;
        logic [31:0]   dout;
        logic [LW-1:0] level;
        logic [31:0]   count;

        bit            prod_en    = 1'b0;
        bit            cons_en    = 1'b0;
        int            prod_fail  = 0;
        int            cons_fail  = 0;
        int            prod_limit = 0;
        int            next_val   = 0;
        int            force_req  = 0;
        int            force_done = 0;
        int            delivered  = 0;
        logic [31:0]   exp_q[$];
        logic [31:0]   last_exp   = 32'd0;
        logic [31:0]   exp_cnt    = 32'd0;
        bit            prev_ack   = 1'b0;

        handshake_fifo #(
            .data_width   (32),
            .depth        (DEPTH),
            .initial_value(32'd0)
        ) u_dut (
            .clk  (clk),
            .rst  (rst),
            .req_l(req_l),
            .ack_l(ack_l),
            .din  (din),
            .req_r(req_r),
            .ack_r(ack_r),
            .dout (dout),
            .level(level),
            .count(count)
        );

        // Producer: one-cycle ack pulses answering req_l; forced acks test the ignore paths.
        initial begin
            forever begin
                @(negedge clk);
                if (ack_l) begin
                    ack_l = 1'b0;
                end else if (force_req != force_done) begin
                    ack_l = 1'b1;
                    din   = 32'hDEAD_BEEF;
                    force_done++;
                end else if (prod_en && !rst && req_l && next_val < prod_limit &&
                             $urandom_range(99) >= prod_fail) begin
                    ack_l = 1'b1;
                    din   = 32'(next_val);
                    exp_q.push_back(32'(next_val));
                    next_val++;
                end
            end
        end

        // Consumer: request level with optional random back-pressure.
        initial begin
            forever begin
                @(negedge clk);
                req_r = cons_en && ($urandom_range(99) >= cons_fail);
            end
        end

        // Monitor: pops the expected queue on every ack_r and checks hold otherwise.
        initial begin
            forever begin
                @(negedge clk);
                check(level <= DEPTH, $sformatf("i%0d_level_range", gi), 64'(level), 64'(DEPTH));
                if (ack_r) begin
                    check(!prev_ack, $sformatf("i%0d_ack_r_gap", gi), 64'(1), 64'(0));
                    check(exp_q.size() != 0, $sformatf("i%0d_word_expected", gi),
                          64'(exp_q.size()), 64'(1));
                    if (exp_q.size() != 0) begin
                        last_exp = exp_q.pop_front();
                        exp_cnt  = exp_cnt + 32'd1;
                        delivered++;
                        check(dout == last_exp, $sformatf("i%0d_dout_order", gi),
                              64'(dout), 64'(last_exp));
                        check(count == exp_cnt, $sformatf("i%0d_count", gi),
                              64'(count), 64'(exp_cnt));
                    end
                end else begin
                    check(dout == last_exp, $sformatf("i%0d_dout_hold", gi),
                          64'(dout), 64'(last_exp));
                end
                prev_ack = ack_r;
                if (rst) begin
                    exp_q.delete();
                    last_exp = 32'd0;
                    exp_cnt  = 32'd0;
                    prev_ack = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int tmo;
        int lat;
        int base;
        int tgt;

        // Reset state
        tick(2);
        check(g_dut[0].req_l == 1'b0, "rst_req_l", 64'(g_dut[0].req_l), 64'(0));
        check(g_dut[0].ack_r == 1'b0, "rst_ack_r", 64'(g_dut[0].ack_r), 64'(0));
        check(g_dut[0].dout == 32'd0, "rst_dout", 64'(g_dut[0].dout), 64'(0));
        check(g_dut[0].level == 3'd0, "rst_level", 64'(g_dut[0].level), 64'(0));
        check(g_dut[0].count == 32'd0, "rst_count", 64'(g_dut[0].count), 64'(0));

        // Test 1 (instance 0) and test 4 (instances 1, 2) run together
        g_dut[0].prod_en = 1'b1; g_dut[0].cons_en = 1'b1; g_dut[0].prod_limit = 5000;
        g_dut[1].prod_en = 1'b1; g_dut[1].cons_en = 1'b1; g_dut[1].prod_limit = 5000;
        g_dut[2].prod_en = 1'b1; g_dut[2].cons_en = 1'b1; g_dut[2].prod_limit = 5000;
        g_dut[1].prod_fail = 30; g_dut[1].cons_fail = 30;
        g_dut[2].prod_fail = 30; g_dut[2].cons_fail = 30;
        tick(1);
        g_dut[0].rst = 1'b0; g_dut[1].rst = 1'b0; g_dut[2].rst = 1'b0;
        lat = 0;
        while (!g_dut[0].ack_r && lat < 10) begin
            tick(1);
            lat++;
        end
        check(lat <= 5, "first_word_latency", 64'(lat), 64'(5));
        check(g_dut[0].dout == 32'd0, "first_word", 64'(g_dut[0].dout), 64'(0));

        tmo = 0;
        while ((g_dut[0].delivered < 5000 || g_dut[1].delivered < 5000 ||
                g_dut[2].delivered < 5000) && tmo < 60000) begin
            tick(1);
            tmo++;
        end
        check(tmo < 60000, "stream_timeout", 64'(tmo), 64'(60000));
        tick(4);
        check(g_dut[0].count == 32'd5000, "t1_count", 64'(g_dut[0].count), 64'(5000));
        check(g_dut[1].count == 32'd5000, "t4_d2_count", 64'(g_dut[1].count), 64'(5000));
        check(g_dut[2].count == 32'd5000, "t4_d8_count", 64'(g_dut[2].count), 64'(5000));

        // Test 2: fill to full, spurious ack while full, then drain
        g_dut[0].cons_en = 1'b0;
        g_dut[0].prod_limit = 5020;
        tick(12);
        check(g_dut[0].level == 3'd4, "t2_full_level", 64'(g_dut[0].level), 64'(4));
        for (int k = 0; k < 5; k++) begin
            check(g_dut[0].req_l == 1'b0, "t2_req_l_full", 64'(g_dut[0].req_l), 64'(0));
            tick(1);
        end
        g_dut[0].force_req++;
        tick(3);
        check(g_dut[0].level == 3'd4, "t2_spurious_ack", 64'(g_dut[0].level), 64'(4));
        check(g_dut[0].count == 32'd5000, "t2_no_pop", 64'(g_dut[0].count), 64'(5000));
        g_dut[0].cons_en = 1'b1;
        tmo = 0;
        while ((g_dut[0].delivered < 5020 || g_dut[0].level != 3'd0) && tmo < 200) begin
            tick(1);
            tmo++;
        end
        check(tmo < 200, "t2_drain_timeout", 64'(tmo), 64'(200));

        // Test 3: empty stall with req_r held, then restart
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check(g_dut[0].ack_r == 1'b0, "t3_no_ack", 64'(g_dut[0].ack_r), 64'(0));
            check(g_dut[0].dout == 32'd5019, "t3_dout_hold", 64'(g_dut[0].dout), 64'(5019));
        end
        g_dut[0].prod_limit = 5021;
        tmo = 0;
        while (g_dut[0].delivered < 5021 && tmo < 50) begin
            tick(1);
            tmo++;
        end
        check(g_dut[0].dout == 32'd5020, "t3_restart", 64'(g_dut[0].dout), 64'(5020));

        // Test 5: reset with three words stored, ack_l arriving on the reset edge
        g_dut[0].cons_en = 1'b0;
        g_dut[0].prod_limit = 5031;
        tmo = 0;
        while (g_dut[0].level != 3'd3 && tmo < 50) begin
            tick(1);
            tmo++;
        end
        g_dut[0].prod_en = 1'b0;
        check(g_dut[0].level == 3'd3, "t5_level3", 64'(g_dut[0].level), 64'(3));
        g_dut[0].rst = 1'b1;
        g_dut[0].force_req++;
        tick(1);
        check(g_dut[0].req_l == 1'b0, "t5_req_l", 64'(g_dut[0].req_l), 64'(0));
        check(g_dut[0].ack_r == 1'b0, "t5_ack_r", 64'(g_dut[0].ack_r), 64'(0));
        check(g_dut[0].dout == 32'd0, "t5_dout", 64'(g_dut[0].dout), 64'(0));
        check(g_dut[0].level == 3'd0, "t5_level", 64'(g_dut[0].level), 64'(0));
        check(g_dut[0].count == 32'd0, "t5_count", 64'(g_dut[0].count), 64'(0));
        g_dut[0].rst = 1'b0;
        tick(2);
        check(g_dut[0].level == 3'd0, "t5_reset_ack_ignored", 64'(g_dut[0].level), 64'(0));
        base = g_dut[0].delivered;
        g_dut[0].prod_en = 1'b1;
        g_dut[0].cons_en = 1'b1;
        tmo = 0;
        while (g_dut[0].delivered < base + 1 && tmo < 50) begin
            tick(1);
            tmo++;
        end
        check(g_dut[0].dout == 32'd5024, "t5_first_after_rst", 64'(g_dut[0].dout), 64'(5024));
        tmo = 0;
        while ((g_dut[0].delivered < base + 7 || g_dut[0].level != 3'd0) && tmo < 100) begin
            tick(1);
            tmo++;
        end
        tick(2);
        check(g_dut[0].count == 32'd7, "t5_count_after", 64'(g_dut[0].count), 64'(7));

        // Test 6: ten words in alternating full / empty phases
        g_dut[0].cons_en = 1'b0;
        g_dut[0].prod_limit = 5041;
        for (int ph = 0; ph < 3; ph++) begin
            tgt = (ph < 2) ? 4 : 2;
            g_dut[0].prod_en = 1'b1;
            tmo = 0;
            while (g_dut[0].level != 3'(tgt) && tmo < 50) begin
                tick(1);
                tmo++;
            end
            g_dut[0].prod_en = 1'b0;
            check(g_dut[0].level == 3'(tgt), "t6_fill", 64'(g_dut[0].level), 64'(tgt));
            g_dut[0].cons_en = 1'b1;
            tmo = 0;
            while (g_dut[0].level != 3'd0 && tmo < 50) begin
                tick(1);
                tmo++;
            end
            tick(2);
            g_dut[0].cons_en = 1'b0;
            check(g_dut[0].level == 3'd0, "t6_drain", 64'(g_dut[0].level), 64'(0));
        end
        tick(2);
        check(g_dut[0].count == 32'd17, "t6_count", 64'(g_dut[0].count), 64'(17));
        check(g_dut[0].dout == 32'd5040, "t6_last_word", 64'(g_dut[0].dout), 64'(5040));

        check(g_dut[0].exp_q.size() == 0, "i0_leftover", 64'(g_dut[0].exp_q.size()), 64'(0));
        check(g_dut[1].exp_q.size() == 0, "i1_leftover", 64'(g_dut[1].exp_q.size()), 64'(0));
        check(g_dut[2].exp_q.size() == 0, "i2_leftover", 64'(g_dut[2].exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/handshake_fifo.md
HANDSHAKE_FIFO -- requirements
Module: handshake_fifo

Interface
REQ-001 Parameter data_width, default 32, width of the data word on both sides.
REQ-002 Parameter depth, default 4, number of storage entries; a power of two and at least 2.
REQ-003 Parameter initial_value, default 0, value driven on dout after reset.
REQ-004 clk  input  1  clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_l  output  1  upstream request; this block acts as requester on the left.
REQ-007 ack_l  input  1  upstream acknowledge, a one-cycle pulse; din is valid in that cycle.
REQ-008 din  input  data_width  upstream data.
REQ-009 req_r  input  1  downstream request; this block acts as responder on the right.
REQ-010 ack_r  output  1  downstream acknowledge, a registered one-cycle pulse.
REQ-011 dout  output  data_width  downstream data, registered, valid while ack_r=1.
REQ-012 level  output  $clog2(depth)+1  number of occupied entries.
REQ-013 count  output  32  number of words delivered downstream; wraps modulo 2^32.

Function
REQ-014 Storage: circular buffer with wr_ptr and rd_ptr, each $clog2(depth) bits and wrapping depth-1->0; level tracks occupancy 0..depth.
REQ-015 Left side, priority order, one edge:
- ack_l=1 -> write din at wr_ptr, advance wr_ptr, drive req_l<=0.
- else if req_l=0 and level<depth -> req_l<=1.
- else hold req_l.
REQ-016 At most one upstream request is outstanding, so the buffer shall never be written while full. An ack_l received while req_l=0 shall be ignored with no write.
REQ-017 Right side, per edge:
- req_r=1, ack_r=0 and level>0 (pre-edge value) -> ack_r<=1, dout<=mem[rd_ptr], advance rd_ptr, count<=count+1.
- otherwise -> ack_r<=0 and hold dout.
REQ-018 ack_r shall never be high on two consecutive cycles, so the peak downstream rate is one word per 2 cycles.
REQ-019 Simultaneous push and pop on one edge: both pointers advance and level is unchanged. A word written on edge N is first servable on edge N+1; there is no write-to-read bypass.
REQ-020 Empty (level=0) with req_r=1: no ack_r; req_r may stay high indefinitely.
REQ-021 Full (level=depth): req_l stays 0 until a pop lowers level.
REQ-022 Ordering: words are delivered strictly in arrival order, with no loss or duplication.
REQ-023 Latency: with an upstream that acks one cycle after req and an always-requesting downstream, the first word appears on dout with ack_r=1 no later than 5 cycles after rst is released.
REQ-024 Pointer wrap-around shall not corrupt data or level for any depth.

Reset
REQ-025 While rst=1: req_l=0, ack_r=0, dout=initial_value, level=0, count=0, wr_ptr=0, rd_ptr=0.
REQ-026 Reset mid-operation discards all stored words. An ack_l arriving on a reset edge shall be ignored.
REQ-027 Memory contents need not be reset.
REQ-028 The first rising edge after rst falls may assert req_l.

Verification
REQ-029 Test 1, basic flow: producer with fail_rate 0 and initial_value 0, consumer with fail_rate 0, depth 4; run 5000 words -> consumer sees 0,1,2,...,4999 in order, count=5000, ack_r never high two cycles in a row.
REQ-030 Test 2, fill to full: consumer holds req_r=0 -> level rises to 4 and req_l stays 0 thereafter. Release req_r -> words 0..3 delivered, then streaming resumes with word 4.
REQ-031 Test 3, empty stall: producer stopped with req_r=1 held -> ack_r stays 0 and dout holds its last value. Producer restarted -> next sequential value is delivered.
REQ-032 Test 4, random back-pressure: producer and consumer fail_rate 30, depth 2 and depth 8 -> in-order sequence intact over 5000 words, level within 0..depth at every cycle.
REQ-033 Test 5, reset mid-stream: rst pulsed for 1 cycle while level=3 -> all outputs at reset values the next cycle. After reset the consumer receives only values sent after reset.
REQ-034 Test 6, wrap: depth 4 and 10 words with alternating full/empty phases -> pointers wrap at least twice and the data is correct.
